// File: rtl/atm_multi_account_ctrl.sv
// atm_multi_account_ctrl: multi-account ATM session controller with on-chip balances, PINs and lock flags.
// Optional per-account daily withdrawal cap is enabled by defining ATM_DAILY_LIMIT_EN.
module atm_multi_account_ctrl #(
    parameter int                  NUM_ACCTS   = 4,
    parameter int                  CARD_W      = 8,
    parameter int                  PIN_W       = 16,
    parameter int                  BAL_W       = 16,
    parameter logic [BAL_W-1:0]    INIT_BAL    = 16'h0500,
    parameter logic [PIN_W-1:0]    DEFAULT_PIN = 16'h1234,
    parameter int                  MAX_TRIES   = 3,
    parameter int                  TIMEOUT     = 255
`ifdef ATM_DAILY_LIMIT_EN
    ,
    parameter logic [BAL_W-1:0]    DAILY_LIMIT = 16'h0200
`endif
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              card_inserted,
    input  logic [CARD_W-1:0] card_number_input,
    input  logic [PIN_W-1:0]  pin_input,
    input  logic              pin_valid,
    input  logic              balance_req,
    input  logic              withdrawal_req,
    input  logic              deposit_req,
    input  logic              pin_change_req,
    input  logic              transaction_done,
    input  logic [BAL_W-1:0]  amount,
`ifdef ATM_DAILY_LIMIT_EN
    input  logic              day_rollover,
`endif
    output logic [7:0]        current_state,
    output logic [BAL_W-1:0]  balance,
    output logic              transaction_success,
    output logic [7:0]        error_code,
    output logic              card_retained
);
    localparam int IDX_W = NUM_ACCTS > 1 ? $clog2(NUM_ACCTS) : 1;
    localparam int TRY_W = $clog2(MAX_TRIES + 1);
    localparam int TMR_W = $clog2(TIMEOUT + 1);

    typedef enum logic [7:0] {
        IDLE       = 8'h00,
        CARD_CHECK = 8'h01,
        PIN_ENTRY  = 8'h02,
        MENU       = 8'h03,
        BALANCE    = 8'h04,
        WITHDRAW   = 8'h05,
        DEPOSIT    = 8'h06,
        PIN_CHANGE = 8'h07,
        DONE       = 8'h08,
        LOCKED     = 8'h09,
        EJECT      = 8'h0A
    } state_t;

    state_t             state_q, state_n;
    logic [IDX_W-1:0]   idx_q, idx_n;
    logic [TRY_W-1:0]   tries_q, tries_n;
    logic [TMR_W-1:0]   timer_q;
    logic [7:0]         err_n;
    logic               succ_n;
    logic [BAL_W-1:0]   bal_q [NUM_ACCTS];
    logic [PIN_W-1:0]   pin_q [NUM_ACCTS];
    logic               lock_q [NUM_ACCTS];
    logic               bal_we, pin_we, lock_we;
    logic [BAL_W-1:0]   bal_wd, cur_bal;
    logic [BAL_W:0]     dep_sum;
    logic [2:0]         req_cnt;
    logic               activity, timed_out;
`ifdef ATM_DAILY_LIMIT_EN
    logic [BAL_W:0]     tot_q [NUM_ACCTS];
    logic [BAL_W:0]     tot_sum;
    logic               tot_we;
`endif

    assign cur_bal  = bal_q[idx_q];
    assign dep_sum  = {1'b0, cur_bal} + {1'b0, amount};
    assign req_cnt  = 3'(balance_req) + 3'(withdrawal_req) + 3'(deposit_req) + 3'(pin_change_req);
    assign activity = pin_valid | (req_cnt != 3'd0) | transaction_done;
    assign timed_out = !activity && timer_q == TMR_W'(TIMEOUT - 1);
`ifdef ATM_DAILY_LIMIT_EN
    assign tot_sum  = tot_q[idx_q] + {1'b0, amount};
`endif

    assign current_state = state_q;
    assign card_retained = state_q == LOCKED;
    assign balance       = (state_q inside {PIN_ENTRY, MENU, BALANCE, WITHDRAW, DEPOSIT, PIN_CHANGE, DONE}) ? cur_bal : '0;

    // next-state, error/success and account-commit decisions
    always_comb begin
        state_n = state_q;
        err_n   = error_code;
        succ_n  = 1'b0;
        idx_n   = idx_q;
        tries_n = tries_q;
        bal_we  = 1'b0;
        bal_wd  = cur_bal;
        pin_we  = 1'b0;
        lock_we = 1'b0;
`ifdef ATM_DAILY_LIMIT_EN
        tot_we  = 1'b0;
`endif
        if (!card_inserted && !(state_q inside {IDLE, LOCKED, EJECT})) begin
            state_n = IDLE;
        end else begin
            case (state_q)
                IDLE: state_n = card_inserted ? CARD_CHECK : IDLE;
                CARD_CHECK: begin
                    err_n = 8'h00;
                    if (card_number_input >= CARD_W'(NUM_ACCTS)) begin
                        err_n   = 8'h01;
                        state_n = EJECT;
                    end else if (lock_q[card_number_input[IDX_W-1:0]]) begin
                        err_n   = 8'h03;
                        state_n = EJECT;
                    end else begin
                        idx_n   = card_number_input[IDX_W-1:0];
                        tries_n = '0;
                        state_n = PIN_ENTRY;
                    end
                end
                PIN_ENTRY: begin
                    if (timed_out) begin
                        err_n   = 8'h05;
                        state_n = EJECT;
                    end else if (pin_valid && pin_input == pin_q[idx_q]) begin
                        err_n   = 8'h00;
                        state_n = MENU;
                    end else if (pin_valid) begin
                        err_n   = 8'h02;
                        tries_n = tries_q + TRY_W'(1);
                        lock_we = tries_n == TRY_W'(MAX_TRIES);
                        state_n = lock_we ? LOCKED : PIN_ENTRY;
                    end
                end
                MENU: begin
                    if (timed_out) begin
                        err_n   = 8'h05;
                        state_n = EJECT;
                    end else if (req_cnt > 3'd1) begin
                        err_n   = 8'h08;
                    end else if (req_cnt == 3'd1) begin
                        state_n = balance_req ? BALANCE : withdrawal_req ? WITHDRAW : deposit_req ? DEPOSIT : PIN_CHANGE;
                    end
                end
                BALANCE: begin
                    succ_n  = 1'b1;
                    err_n   = 8'h00;
                    state_n = DONE;
                end
                WITHDRAW: begin
                    state_n = DONE;
                    if (amount == '0 || amount > cur_bal) begin
                        err_n = 8'h04;
`ifdef ATM_DAILY_LIMIT_EN
                    end else if (tot_sum > {1'b0, DAILY_LIMIT}) begin
                        err_n = 8'h07;
`endif
                    end else begin
                        bal_we = 1'b1;
                        bal_wd = cur_bal - amount;
                        succ_n = 1'b1;
                        err_n  = 8'h00;
`ifdef ATM_DAILY_LIMIT_EN
                        tot_we = 1'b1;
`endif
                    end
                end
                DEPOSIT: begin
                    state_n = DONE;
                    if (dep_sum[BAL_W]) begin
                        err_n = 8'h06;
                    end else begin
                        bal_we = 1'b1;
                        bal_wd = dep_sum[BAL_W-1:0];
                        succ_n = 1'b1;
                        err_n  = 8'h00;
                    end
                end
                PIN_CHANGE: begin
                    pin_we  = 1'b1;
                    succ_n  = 1'b1;
                    err_n   = 8'h00;
                    state_n = DONE;
                end
                DONE: begin
                    if (timed_out) begin
                        err_n   = 8'h05;
                        state_n = EJECT;
                    end else if (transaction_done) begin
                        state_n = MENU;
                    end else begin
                        succ_n  = transaction_success;
                    end
                end
                LOCKED, EJECT: state_n = card_inserted ? state_q : IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    // session control registers; idle timer restarts on state change or user activity
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q             <= IDLE;
            idx_q               <= '0;
            tries_q             <= '0;
            timer_q             <= '0;
            error_code          <= 8'h00;
            transaction_success <= 1'b0;
        end else begin
            state_q             <= state_n;
            idx_q               <= idx_n;
            tries_q             <= tries_n;
            timer_q             <= (state_n != state_q || activity) ? '0 : timer_q + TMR_W'(1);
            error_code          <= err_n;
            transaction_success <= succ_n;
        end
    end

    // per-account balances, PINs and lock flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ACCTS; i++) begin
                bal_q[i]  <= INIT_BAL;
                pin_q[i]  <= DEFAULT_PIN;
                lock_q[i] <= 1'b0;
            end
        end else begin
            if (bal_we) bal_q[idx_q] <= bal_wd;
            if (pin_we) pin_q[idx_q] <= pin_input;
            if (lock_we) lock_q[idx_q] <= 1'b1;
        end
    end

`ifdef ATM_DAILY_LIMIT_EN
    // daily withdrawn totals; a rollover pulse overrides a same-cycle update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_ACCTS; i++) tot_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_ACCTS; i++) begin
                if (day_rollover) tot_q[i] <= '0;
                else if (tot_we && idx_q == IDX_W'(i)) tot_q[i] <= tot_sum;
            end
        end
    end
`endif
endmodule

// File: tb/tb_atm_multi_account_ctrl.sv
// tb_atm_multi_account_ctrl: directed and randomized checks of the ATM controller against an account-level model.
module tb_atm_multi_account_ctrl;
`ifdef ATM_DAILY_LIMIT_EN
    localparam bit DL_EN = 1'b1;
`else
    localparam bit DL_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        card_inserted = 1'b0;
    logic [7:0]  card_number_input = '0;
    logic [15:0] pin_input = '0;
    logic        pin_valid = 1'b0;
    logic        balance_req = 1'b0, withdrawal_req = 1'b0, deposit_req = 1'b0, pin_change_req = 1'b0;
    logic        transaction_done = 1'b0;
    logic [15:0] amount = '0;
    logic        day_rollover = 1'b0;
    logic [7:0]  current_state;
    logic [15:0] balance;
    logic        transaction_success;
    logic [7:0]  error_code;
    logic        card_retained;

    int checks = 0;
    int errors = 0;

    logic [15:0] m_bal  [4];
    logic [15:0] m_pin  [4];
    bit          m_lock [4];
    int          m_tot  [4];
    int          cur = 0;

    atm_multi_account_ctrl dut (
        .clk(clk), .rst_n(rst_n), .card_inserted(card_inserted),
        .card_number_input(card_number_input), .pin_input(pin_input), .pin_valid(pin_valid),
        .balance_req(balance_req), .withdrawal_req(withdrawal_req), .deposit_req(deposit_req),
        .pin_change_req(pin_change_req), .transaction_done(transaction_done), .amount(amount),
`ifdef ATM_DAILY_LIMIT_EN
        .day_rollover(day_rollover),
`endif
        .current_state(current_state), .balance(balance), .transaction_success(transaction_success),
        .error_code(error_code), .card_retained(card_retained)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_bal[i]  = 16'h0500;
            m_pin[i]  = 16'h1234;
            m_lock[i] = 1'b0;
            m_tot[i]  = 0;
        end
    endtask

    task automatic insert(input logic [7:0] card);
        card_inserted = 1'b1;
        card_number_input = card;
        tick();
        chk("card_check_state", current_state, 8'h01);
        tick();
    endtask

    task automatic enter_pin(input logic [15:0] p);
        pin_input = p;
        pin_valid = 1'b1;
        tick();
        pin_valid = 1'b0;
    endtask

    task automatic eject();
        card_inserted = 1'b0;
        tick();
        chk("eject_state", current_state, 8'h00);
        chk("eject_balance", balance, 16'h0000);
    endtask

    task automatic login(input int c, input bit wrong_first);
        cur = c;
        insert(8'(c));
        chk("pin_entry_state", current_state, 8'h02);
        if (wrong_first) begin
            enter_pin(m_pin[c] ^ 16'h0101);
            chk("wrong_pin_err", error_code, 8'h02);
            chk("wrong_pin_state", current_state, 8'h02);
        end
        enter_pin(m_pin[c]);
        chk("login_state", current_state, 8'h03);
        chk("login_err", error_code, 8'h00);
        chk("login_balance", balance, 32'(m_bal[c]));
    endtask

    // kind: 0 balance, 1 withdraw, 2 deposit, 3 pin change (amt is the new PIN)
    task automatic do_op(input int kind, input logic [15:0] amt);
        int b, a;
        logic [7:0] e;
        logic s;
        b = int'(m_bal[cur]);
        a = int'(amt);
        e = 8'h00;
        s = 1'b1;
        if (kind == 1) begin
            if (a == 0 || a > b) begin e = 8'h04; s = 1'b0; end
            else if (DL_EN && m_tot[cur] + a > 'h200) begin e = 8'h07; s = 1'b0; end
            else begin b = b - a; m_tot[cur] += a; end
        end else if (kind == 2) begin
            if (b + a > 65535) begin e = 8'h06; s = 1'b0; end
            else b = b + a;
        end else if (kind == 3) begin
            m_pin[cur] = amt;
        end
        balance_req    = kind == 0;
        withdrawal_req = kind == 1;
        deposit_req    = kind == 2;
        pin_change_req = kind == 3;
        amount         = amt;
        pin_input      = amt;
        tick();
        balance_req = 1'b0; withdrawal_req = 1'b0; deposit_req = 1'b0; pin_change_req = 1'b0;
        chk("op_state", current_state, 32'(4 + kind));
        tick();
        m_bal[cur] = 16'(b);
        chk("done_state", current_state, 8'h08);
        chk("done_success", transaction_success, s);
        chk("done_err", error_code, e);
        chk("done_balance", balance, 32'(m_bal[cur]));
        transaction_done = 1'b1;
        tick();
        transaction_done = 1'b0;
        chk("ack_state", current_state, 8'h03);
        chk("ack_success", transaction_success, 1'b0);
    endtask

    initial begin
        bit found;
        model_reset();
        tick(); tick();
        chk("rst_state", current_state, 8'h00);
        chk("rst_balance", balance, 16'h0000);
        chk("rst_success", transaction_success, 1'b0);
        chk("rst_err", error_code, 8'h00);
        chk("rst_retained", card_retained, 1'b0);
        rst_n = 1'b1;
        tick();

        login(0, 1'b0);
        do_op(0, 16'h0000);
        chk("t1_balance", balance, 16'h0500);
        do_op(1, 16'h0050);
        chk("t2_balance", balance, 16'h04B0);
        do_op(1, 16'h0600);
        chk("t2_err_kept", error_code, 8'h04);
        eject();

        insert(8'h01);
        for (int i = 0; i < 2; i++) begin
            enter_pin(16'h0000);
            chk("t3_err", error_code, 8'h02);
            chk("t3_state", current_state, 8'h02);
            tick();
        end
        enter_pin(16'h0000);
        m_lock[1] = 1'b1;
        chk("t3_locked", current_state, 8'h09);
        chk("t3_retained", card_retained, 1'b1);
        eject();
        insert(8'h01);
        chk("t3_relock_err", error_code, 8'h03);
        chk("t3_relock_state", current_state, 8'h0A);
        eject();

        insert(8'h07);
        chk("t4_bad_card_err", error_code, 8'h01);
        chk("t4_bad_card_state", current_state, 8'h0A);
        eject();
        login(2, 1'b0);
        do_op(2, 16'hFFF0);
        chk("t4_ovf_err", error_code, 8'h06);
        do_op(2, 16'hFAFF);
        chk("t4_full_balance", balance, 16'hFFFF);
        do_op(2, 16'h0001);
        do_op(1, 16'h0000);
        do_op(1, 16'hFFFF);
        balance_req = 1'b1;
        deposit_req = 1'b1;
        tick();
        balance_req = 1'b0;
        deposit_req = 1'b0;
        chk("t4_multi_err", error_code, 8'h08);
        chk("t4_multi_state", current_state, 8'h03);
        eject();

        cur = 3;
        insert(8'h03);
        for (int i = 0; i < 250; i++) tick();
        chk("t5_pre_timeout_state", current_state, 8'h02);
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            tick();
            found = current_state == 8'h0A;
        end
        chk("t5_timeout_state", current_state, 8'h0A);
        chk("t5_timeout_err", error_code, 8'h05);
        eject();

`ifdef ATM_DAILY_LIMIT_EN
        login(3, 1'b0);
        do_op(1, 16'h0150);
        do_op(1, 16'h00C0);
        chk("t6_limit_err", error_code, 8'h07);
        day_rollover = 1'b1;
        tick();
        day_rollover = 1'b0;
        for (int i = 0; i < 4; i++) m_tot[i] = 0;
        do_op(1, 16'h00C0);
        chk("t6_retry_success_err", error_code, 8'h00);
        eject();
`endif

        for (int s = 0; s < 25; s++) begin
            int c, n;
            do c = $urandom_range(0, 3); while (m_lock[c]);
            if (DL_EN && s % 5 == 0) begin
                day_rollover = 1'b1;
                tick();
                day_rollover = 1'b0;
                for (int i = 0; i < 4; i++) m_tot[i] = 0;
            end
            login(c, $urandom_range(0, 3) == 0);
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) begin
                int kind, r;
                logic [15:0] amt;
                kind = $urandom_range(0, 3);
                r = $urandom_range(0, 3);
                amt = r == 0 ? 16'h0000 : r == 1 ? 16'($urandom_range(1, 'h200)) :
                      r == 2 ? m_bal[cur] : 16'($urandom_range(0, 'hFFFF));
                do_op(kind, amt);
            end
            eject();
        end

        login(0, 1'b0);
        do_op(2, 16'h0010);
        #3;
        rst_n = 1'b0;
        card_inserted = 1'b0;
        #1;
        chk("async_rst_state", current_state, 8'h00);
        chk("async_rst_balance", balance, 16'h0000);
        chk("async_rst_err", error_code, 8'h00);
        model_reset();
        tick();
        rst_n = 1'b1;
        tick();
        login(1, 1'b0);
        chk("post_rst_balance", balance, 16'h0500);
        eject();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
